// File: rtl/frame_pkg.sv
// frame_pkg: shared sample width, frame record and saturating add for frame-level stages
package frame_pkg;
  localparam int SAMPLE_W = 8;
  localparam int MAX_SUM_W = 32;
  typedef struct packed {
    logic [MAX_SUM_W-1:0] sum;
    logic [SAMPLE_W-1:0]  max;
    logic [7:0]           len;
    logic                 sat;
  } frame_t;
  // Returns {overflow, sum clamped to 2**w-1}; w may be 1..MAX_SUM_W
  function automatic logic [MAX_SUM_W:0] sat_add(input logic [MAX_SUM_W-1:0] a,
                                                 input logic [SAMPLE_W-1:0] b,
                                                 input int unsigned w);
    logic [MAX_SUM_W:0] s;
    logic [MAX_SUM_W:0] lim;
    s = {1'b0, a} + (MAX_SUM_W+1)'(b);
    lim = ((MAX_SUM_W+1)'(1) << w) - (MAX_SUM_W+1)'(1);
    return (s > lim) ? {1'b1, lim[MAX_SUM_W-1:0]} : {1'b0, s[MAX_SUM_W-1:0]};
  endfunction
endpackage

// File: rtl/frame_out_reg.sv
// frame_out_reg: single-entry valid/ready frame holding register with saturating drop count
module frame_out_reg
  import frame_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  frame_t           din,
  input  logic             ready,
  output logic             valid,
  output frame_t           dout,
  output logic [CNT_W-1:0] drop_cnt
);
  logic free;
  assign free = !valid || ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      dout     <= '0;
      drop_cnt <= '0;
    end else begin
      if (load && free) begin
        valid <= 1'b1;
        dout  <= din;
      end else if (ready) begin
        valid <= 1'b0;
      end
      if (load && !free && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/frame_accumulator.sv
// frame_accumulator: sums FRAME_LEN samples into saturating frames with max tracking,
// delivered through a holding register that drops frames when it is still full
module frame_accumulator
  import frame_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int SUM_W     = 16,
  parameter int CNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_in,
  input  logic [SAMPLE_W-1:0] data_in,
  input  logic                flush,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [SUM_W-1:0]    out_sum,
  output logic [SAMPLE_W-1:0] out_max,
  output logic [7:0]          out_len,
  output logic                out_sat,
  output logic [CNT_W-1:0]    drop_cnt
);
  logic [MAX_SUM_W-1:0] acc;
  logic [SAMPLE_W-1:0]  max_q;
  logic [7:0]           cnt;
  logic                 sat_q;
  logic [MAX_SUM_W:0]   add;
  logic                 close;
  logic                 unused_hi;
  frame_t               nxt;
  frame_t               held;
  // nxt is the frame including this cycle's sample, used both to update and to close
  always_comb begin
    add      = sat_add(acc, data_in, SUM_W);
    nxt.sum  = valid_in ? add[MAX_SUM_W-1:0] : acc;
    nxt.sat  = sat_q | (valid_in & add[MAX_SUM_W]);
    nxt.max  = (valid_in && data_in > max_q) ? data_in : max_q;
    nxt.len  = cnt + 8'(valid_in);
    close    = (valid_in && cnt == 8'(FRAME_LEN - 1)) || (flush && nxt.len != 8'd0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      max_q <= '0;
      cnt   <= '0;
      sat_q <= 1'b0;
    end else if (close) begin
      acc   <= '0;
      max_q <= '0;
      cnt   <= '0;
      sat_q <= 1'b0;
    end else begin
      acc   <= nxt.sum;
      max_q <= nxt.max;
      cnt   <= nxt.len;
      sat_q <= nxt.sat;
    end
  end
  frame_out_reg #(.CNT_W(CNT_W)) u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (close),
    .din      (nxt),
    .ready    (out_ready),
    .valid    (out_valid),
    .dout     (held),
    .drop_cnt (drop_cnt)
  );
  assign out_sum   = held.sum[SUM_W-1:0];
  assign out_max   = held.max;
  assign out_len   = held.len;
  assign out_sat   = held.sat;
  assign unused_hi = ^held.sum;
endmodule

// File: tb/tb_frame_accumulator.sv
// tb_frame_accumulator: directed checks of frame accumulation, saturation, drops, flush and reset
module tb_frame_accumulator;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_in = 1'b0;
  logic [7:0] data_in = '0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic        a_valid, b_valid, a_sat, b_sat;
  logic [15:0] a_sum;
  logic [9:0]  b_sum;
  logic [7:0]  a_max, b_max, a_len, b_len, a_drop, b_drop;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  frame_accumulator #(.FRAME_LEN(16), .SUM_W(16), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in), .flush(flush),
    .out_ready(out_ready), .out_valid(a_valid), .out_sum(a_sum), .out_max(a_max),
    .out_len(a_len), .out_sat(a_sat), .drop_cnt(a_drop)
  );
  frame_accumulator #(.FRAME_LEN(16), .SUM_W(10), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in), .flush(flush),
    .out_ready(out_ready), .out_valid(b_valid), .out_sum(b_sum), .out_max(b_max),
    .out_len(b_len), .out_sat(b_sat), .drop_cnt(b_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    flush = 1'b0;
    data_in = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input int n, input logic [7:0] d);
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b1;
      data_in = d;
      @(negedge clk);
    end
    valid_in = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_valid", a_valid, 0);
    chk("rst_sum", a_sum, 0);
    chk("rst_drop", a_drop, 0);
    // 1: basic frame of 0x02
    out_ready = 1'b1;
    send(15, 8'h02);
    chk("t1_not_yet", a_valid, 0);
    send(1, 8'h02);
    chk("t1_valid", a_valid, 1);
    chk("t1_sum", a_sum, 32);
    chk("t1_max", a_max, 2);
    chk("t1_len", a_len, 16);
    chk("t1_sat", a_sat, 0);
    @(negedge clk);
    chk("t1_one_cycle", a_valid, 0);
    // 2: saturation on the 10-bit instance
    do_reset();
    send(16, 8'hFF);
    chk("t2_b_valid", b_valid, 1);
    chk("t2_b_sum", b_sum, 1023);
    chk("t2_b_sat", b_sat, 1);
    chk("t2_b_max", b_max, 255);
    chk("t2_b_len", b_len, 16);
    chk("t2_a_sum", a_sum, 4080);
    chk("t2_a_sat", a_sat, 0);
    // 3: held frame, two drops, then delivery
    do_reset();
    out_ready = 1'b0;
    send(48, 8'h01);
    chk("t3_valid", a_valid, 1);
    chk("t3_sum", a_sum, 16);
    chk("t3_len", a_len, 16);
    chk("t3_drop", a_drop, 2);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_delivered", a_valid, 0);
    chk("t3_drop_kept", a_drop, 2);
    // 4: accept and load in the same cycle
    do_reset();
    out_ready = 1'b0;
    send(16, 8'h01);
    for (int i = 0; i < 16; i++) begin
      valid_in = 1'b1;
      data_in = 8'h04;
      if (i == 8) chk("t4_stable", a_sum, 16);
      if (i == 15) begin
        out_ready = 1'b1;
        chk("t4_held_valid", a_valid, 1);
        chk("t4_held_sum", a_sum, 16);
      end
      @(negedge clk);
    end
    valid_in = 1'b0;
    chk("t4_second_valid", a_valid, 1);
    chk("t4_second_sum", a_sum, 64);
    chk("t4_drop", a_drop, 0);
    @(negedge clk);
    chk("t4_drained", a_valid, 0);
    // 5: flush with a sample, then flush alone
    do_reset();
    out_ready = 1'b1;
    send(5, 8'h10);
    valid_in = 1'b1;
    data_in = 8'h20;
    flush = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    flush = 1'b1;
    chk("t5_valid", a_valid, 1);
    chk("t5_sum", a_sum, 16'h70);
    chk("t5_max", a_max, 8'h20);
    chk("t5_len", a_len, 6);
    @(negedge clk);
    flush = 1'b0;
    chk("t5_accepted", a_valid, 0);
    @(negedge clk);
    chk("t5_empty_flush", a_valid, 0);
    send(16, 8'h01);
    chk("t5_next_sum", a_sum, 16);
    chk("t5_next_len", a_len, 16);
    // 6: async reset with held frame and partial frame
    do_reset();
    out_ready = 1'b0;
    send(32, 8'h05);
    send(7, 8'h03);
    chk("t6_pre_drop", a_drop, 1);
    chk("t6_pre_sum", a_sum, 80);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", a_valid, 0);
    chk("t6_rst_sum", a_sum, 0);
    chk("t6_rst_max", a_max, 0);
    chk("t6_rst_len", a_len, 0);
    chk("t6_rst_drop", a_drop, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_idle", a_valid, 0);
    send(16, 8'h03);
    chk("t6_valid", a_valid, 1);
    chk("t6_sum", a_sum, 48);
    chk("t6_len", a_len, 16);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
